// File: rtl/outlier_mask_builder_if.sv
// Outlier FIFO pop port between the validation controller and the mask builder.
// master = consumer issuing pops, slave = FIFO returning data.
interface outlier_mask_builder_if #(
  parameter int N = 16
);
  logic [N-1:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_rd_en
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    input  fifo_rd_en
  );
endinterface

// File: rtl/outlier_mask_builder.sv
// Drains outlier indices into a per-point bitmap RAM and counts them.
// Define OUTLIER_DUP_CHECK_EN to count a repeated index only once.
module outlier_mask_builder #(
  parameter  int N          = 16,
  parameter  int WORD_W     = 32,
  parameter  int MAX_POINTS = 4096,
  localparam int DEPTH      = MAX_POINTS / WORD_W,
  localparam int AW         = $clog2(DEPTH),
  localparam int BW         = $clog2(WORD_W)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [2*N-1:0]      point_cloud_size,
  outlier_mask_builder_if.master fifo,
  input  logic                ctrl_done,
  input  logic [AW-1:0]       mask_addr,
  output logic [WORD_W-1:0]   mask_data,
  output logic [N-1:0]        outlier_count,
  output logic                busy,
  output logic                done,
  output logic                err_range
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] POLL    = 3'd2;
  localparam logic [2:0] POP     = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] MODIFY  = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [N:0]    MAX_N    = (N+1)'(MAX_POINTS);
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  logic [2:0]         state;
  logic [2:0]         nxt;
  logic [2*N-1:0]     size_q;
  logic [AW-1:0]      clr_addr;
  logic [BW+AW-1:0]   idx_q;
  logic [WORD_W-1:0]  rd_q;
  logic [WORD_W-1:0]  mem [DEPTH];

  logic               host_ok;
  logic               in_range;
  logic               dup_hit;
  logic [AW-1:0]      raddr;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [WORD_W-1:0]  mem_wdata;
  logic [WORD_W-1:0]  bit_sel;

  assign host_ok = (state == IDLE) || (state == DONE);

  assign in_range =
    ({{N{1'b0}}, fifo.fifo_dout} < size_q) &&
    ({1'b0, fifo.fifo_dout} < MAX_N);

  assign bit_sel = WORD_W'(1) << idx_q[BW-1:0];

`ifdef OUTLIER_DUP_CHECK_EN
  assign dup_hit = rd_q[idx_q[BW-1:0]];
`else
  assign dup_hit = 1'b0;
`endif

  // Single read port: CAPTURE fetches the target word, otherwise the host address
  assign raddr = (state == CAPTURE) ? fifo.fifo_dout[BW +: AW] : mask_addr;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = CLEAR;
      CLEAR:   if (clr_addr == LAST_ADR) nxt = POLL;
      POLL: begin
        if (!fifo.fifo_empty) nxt = POP;
        else if (ctrl_done)   nxt = DONE;
      end
      POP:     nxt = CAPTURE;
      CAPTURE: nxt = in_range ? MODIFY : POLL;
      MODIFY:  nxt = POLL;
      DONE:    if (start) nxt = CLEAR;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = '0;
    unique case (1'b1)
      (state == CLEAR): begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = '0;
      end
      (state == MODIFY): begin
        mem_we    = 1'b1;
        mem_waddr = idx_q[BW +: AW];
        mem_wdata = rd_q | bit_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      size_q        <= '0;
      clr_addr      <= '0;
      idx_q         <= '0;
      outlier_count <= '0;
      err_range     <= 1'b0;
    end else begin
      state <= nxt;
      if (host_ok && start) begin
        size_q        <= point_cloud_size;
        clr_addr      <= '0;
        outlier_count <= '0;
        err_range     <= 1'b0;
      end
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (state == CAPTURE) begin
        idx_q <= fifo.fifo_dout[BW+AW-1:0];
        if (!in_range) err_range <= 1'b1;
      end
      if (state == MODIFY && !dup_hit && outlier_count != '1)
        outlier_count <= outlier_count + 1'b1;
    end
  end

  // Bitmap contents are deliberately not reset; start clears them
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= mem[raddr];
  end

  assign mask_data       = host_ok ? rd_q : '0;
  assign busy            = !host_ok;
  assign done            = (state == DONE);
  assign fifo.fifo_rd_en = (state == POP);

endmodule

// File: doc/outlier_mask_builder.md
# outlier_mask_builder

Downstream consumer of the validation controller's outlier FIFO. Drains outlier point indices (16-bit, one per FIFO pop), sets the corresponding bit in an on-chip per-point bitmap (1 = outlier), counts distinct outliers, and signals completion once the controller reports done and the FIFO is empty. The finished bitmap is readable word-by-word by the host or DMA stage.

## Interface
- N, 16, index width; matches controller point index width
- WORD_W, 32, bitmap RAM word width; power of two
- MAX_POINTS, 4096, bitmap capacity in points; multiple of WORD_W
- Derived: DEPTH = MAX_POINTS/WORD_W; AW = clog2(DEPTH)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse: clear bitmap, counters and flags, then begin draining
- point_cloud_size  in  2N  number of valid points; latched on start
- fifo_dout  in  N  outlier index from controller FIFO; valid one cycle after fifo_rd_en
- fifo_empty  in  1  controller FIFO empty
- fifo_rd_en  out  1  pop request to controller FIFO
- ctrl_done  in  1  controller has finished validating the cloud
- mask_addr  in  AW  host bitmap word address
- mask_data  out  WORD_W  bitmap word; bit b of word w = point w*WORD_W+b
- outlier_count  out  N  outliers recorded
- busy  out  1  clearing or draining
- done  out  1  sticky completion flag
- err_range  out  1  sticky; an index >= latched size or >= MAX_POINTS was received

## Operation
- FSM states: IDLE, CLEAR, POLL, POP, CAPTURE, MODIFY, DONE.
- IDLE: busy=0. Waits for start. start → CLEAR; latch point_cloud_size; zero outlier_count, err_range, done.
- CLEAR: write 0 to one word per cycle, addresses 0..DEPTH-1, then → POLL. Takes DEPTH cycles.
- POLL: if fifo_empty=0 → POP; else if ctrl_done=1 → DONE; else stay.
- POP: fifo_rd_en=1 for exactly this cycle → CAPTURE.
- CAPTURE: register fifo_dout as idx. If idx (zero-extended to 2N) >= latched size or idx >= MAX_POINTS: set err_range, no RAM access, → POLL. Otherwise issue RAM read at word idx/WORD_W → MODIFY.
- MODIFY: write back read word OR (1 << idx%WORD_W); increment outlier_count (saturates at 2^N-1) → POLL.
- DONE: done=1, busy=0. Stays until start (→ CLEAR) or reset.
- start is ignored in CLEAR, POLL, POP, CAPTURE and MODIFY.
- Host read port: mask_data is the registered RAM output for mask_addr, one-cycle latency, whenever the FSM is in IDLE or DONE. In any other state mask_data is 0.
- Bitmap RAM contents are not reset by reset. A start is required before the bitmap is meaningful.

## Timing
- Reset values: fifo_rd_en=0, mask_data=0, outlier_count=0, busy=0, done=0, err_range=0, state IDLE.
- Throughput: one index per 4 cycles (POLL, POP, CAPTURE, MODIFY) when the FIFO is non-empty.
- Latency from start to the first possible pop: DEPTH+2 cycles.
- fifo_rd_en is never asserted while fifo_empty=1, and never in two consecutive cycles.
- ctrl_done with fifo_empty=0: drain continues. DONE is entered only from POLL with empty=1 and ctrl_done=1.
- RAM read-during-write is not exercised, because MODIFY is always followed by POLL.
- Reset mid-drain: FSM returns to IDLE immediately. Any outstanding FIFO word is dropped; the controller's FIFO is reset alongside.

## Configuration
- OUTLIER_DUP_CHECK_EN defined: in MODIFY, if the target bit is already 1, no increment occurs and err_range is unaffected. Duplicate indices are counted once.
- Not defined: outlier_count increments on every in-range pop, duplicates included. The bitmap result is identical in both builds.

## Test plan
- Reset, then start with size=100, FIFO preloaded {3,37,99}, then ctrl_done → word0=0x00000008, word1=0x00000020, word3=0x00000008, count=3, done=1, err_range=0.
- Index 100 with size=100, and index 5000 with size=8000 → both discarded, err_range=1, count unchanged, bitmap all zero.
- Index 7 pushed twice → bit 7 set; count=1 with OUTLIER_DUP_CHECK_EN defined, count=2 without.
- ctrl_done asserted while 4 entries remain in the FIFO → all 4 recorded before done rises; fifo_rd_en never asserted while empty.
- Second start after DONE with new indices {0,31} → previous bits cleared; word0=0x80000001, count=2.
- reset pulsed during MODIFY → all outputs at reset values next cycle; a following start yields a clean bitmap.
